// File: rtl/time_display_scan_if.sv
// -----------------------------------------------------------------------------
// time_display_scan_if
// Bundles the time word, blanking control and display drive lines between
// the display scanner and whatever feeds it / observes it.
//   time_in : {min[5:0], sec[5:0], msec[5:0]}, each field binary 0..63
//   blank   : 1 turns all digits off
//   seg_n   : active-low segments {g,f,e,d,c,b,a}
//   dp_n    : active-low decimal point
//   an_n    : active-low digit enables, bit k = digit k
// master : the side supplying time_in/blank (upstream stage or bench)
// slave  : the scanner itself
// -----------------------------------------------------------------------------
interface time_display_scan_if;
   logic [17:0] time_in;
   logic        blank;
   logic [6:0]  seg_n;
   logic        dp_n;
   logic [5:0]  an_n;

   modport master (
      output time_in,
      output blank,
      input  seg_n,
      input  dp_n,
      input  an_n
   );

   modport slave (
      input  time_in,
      input  blank,
      output seg_n,
      output dp_n,
      output an_n
   );
endinterface

// File: rtl/time_display_scan.sv
// -----------------------------------------------------------------------------
// time_display_scan
// Multiplexed six-digit common-anode seven-segment driver for a packed
// {min, sec, msec} time word. The word is snapshotted once per scan frame so
// a frame never mixes two different time values; each field is split into
// BCD tens/ones (values >= 60 show dashes) and digits are lit one at a time
// for SCAN_DIV clock cycles each.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : slave side of time_display_scan_if (time_in, blank -> seg_n,
//           dp_n, an_n; all outputs registered)
// Digit map: 0/1 = msec ones/tens, 2/3 = sec ones/tens, 4/5 = min ones/tens.
// -----------------------------------------------------------------------------
module time_display_scan #(
   parameter int unsigned SCAN_DIV = 50000
) (
   input  logic                clk,
   input  logic                rst_n,
   time_display_scan_if.slave  bus
);

   localparam int unsigned     CNT_W   = $clog2(SCAN_DIV);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);

   // ---------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------
   logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
   logic [2:0]       idx_q, idx_d;
   logic [17:0]      snap_q, snap_d;
   logic [6:0]       seg_n_q, seg_n_d;
   logic             dp_n_q, dp_n_d;
   logic [5:0]       an_n_q, an_n_d;

   logic tc;
   logic frame_end;

   assign tc        = (div_cnt_q == CNT_MAX);
   assign frame_end = tc && (idx_q == 3'd5);

   // ---------------------------------------------------------------------
   // Per-field BCD split of the snapshot: field 0 = msec, 1 = sec, 2 = min
   // ---------------------------------------------------------------------
   logic [3:0] tens_w [3];
   logic [3:0] ones_w [3];
   logic       dash_w [3];

   for (genvar gi = 0; gi < 3; gi++) begin : g_field
      logic [5:0] field_w;
      logic [5:0] tens_full_w;
      logic [5:0] ones_full_w;
      assign field_w     = snap_q[6*gi +: 6];
      assign tens_full_w = field_w / 6'd10;
      assign ones_full_w = field_w % 6'd10;
      assign tens_w[gi]  = tens_full_w[3:0];
      assign ones_w[gi]  = ones_full_w[3:0];
      // 60..63 cannot be a valid minute/second/msec-tick value
      assign dash_w[gi]  = (field_w > 6'd59);
   end

   // Active-low common-anode segment code, {g,f,e,d,c,b,a}
   function automatic logic [6:0] seg_code(input logic [3:0] d);
      logic [6:0] c;
      case (d)
         4'd0:    c = 7'h40;
         4'd1:    c = 7'h79;
         4'd2:    c = 7'h24;
         4'd3:    c = 7'h30;
         4'd4:    c = 7'h19;
         4'd5:    c = 7'h12;
         4'd6:    c = 7'h02;
         4'd7:    c = 7'h78;
         4'd8:    c = 7'h00;
         4'd9:    c = 7'h10;
         default: c = 7'h3F;
      endcase
      return c;
   endfunction

   // ---------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------
   always_comb begin
      div_cnt_d = div_cnt_q;
      idx_d     = idx_q;
      snap_d    = snap_q;

      if (tc) begin
         div_cnt_d = '0;
         idx_d     = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
      end else begin
         div_cnt_d = div_cnt_q + CNT_W'(1);
      end

      // Frame boundary: the new word first appears on digit 0 of the next
      // frame because idx wraps on this same edge.
      if (frame_end) begin
         snap_d = bus.time_in;
      end
   end

   // ---------------------------------------------------------------------
   // Output decode (registered below, so outputs trail idx by one cycle)
   // ---------------------------------------------------------------------
   always_comb begin
      logic [3:0] digit;
      logic       dash;

      digit = 4'd0;
      dash  = 1'b0;

      // idx[2:1] picks the field, idx[0] picks tens over ones
      case (idx_q[2:1])
         2'd0: begin
            digit = idx_q[0] ? tens_w[0] : ones_w[0];
            dash  = dash_w[0];
         end
         2'd1: begin
            digit = idx_q[0] ? tens_w[1] : ones_w[1];
            dash  = dash_w[1];
         end
         2'd2: begin
            digit = idx_q[0] ? tens_w[2] : ones_w[2];
            dash  = dash_w[2];
         end
         default: begin
            digit = 4'd0;
            dash  = 1'b1;
         end
      endcase

      seg_n_d = dash ? 7'h3F : seg_code(digit);
      // Decimal points sit on sec ones and min ones to separate fields
      dp_n_d  = !((idx_q == 3'd2) || (idx_q == 3'd4));
      an_n_d  = ~(6'b000001 << idx_q);

      if (bus.blank) begin
         seg_n_d = 7'h7F;
         dp_n_d  = 1'b1;
         an_n_d  = 6'h3F;
      end
   end

   // ---------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt_q <= '0;
         idx_q     <= 3'd0;
         snap_q    <= 18'd0;
         seg_n_q   <= 7'h7F;
         dp_n_q    <= 1'b1;
         an_n_q    <= 6'h3F;
      end else begin
         div_cnt_q <= div_cnt_d;
         idx_q     <= idx_d;
         snap_q    <= snap_d;
         seg_n_q   <= seg_n_d;
         dp_n_q    <= dp_n_d;
         an_n_q    <= an_n_d;
      end
   end

   assign bus.seg_n = seg_n_q;
   assign bus.dp_n  = dp_n_q;
   assign bus.an_n  = an_n_q;

endmodule
